ram_arbiter: RTL and testbench

- Two-master arbiter sharing the single-port synchronous data RAM between the RISC-V data bus (master 0) and a secondary requester such as DMA or a debug port (master 1).
- Decides the owner every cycle with round-robin priority and a burst limit.
- Muxes address, write data and byte/half/word write strobes onto the RAM port.
- Returns a per-master read-valid strobe aligned to the RAM's 1-cycle read latency.

---
 rtl/ram_arbiter.sv | 72 +++++++
 tb/tb_ram_arbiter.sv | 97 +++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin, burst-limited two-master arbiter for a single-port synchronous RAM
module ram_arbiter #(
  parameter int ADDR_BUS_LEN = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_BURST    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_req_i,
  input  logic                    m1_req_i,
  input  logic [ADDR_BUS_LEN-1:0] m0_addr_i,
  input  logic [ADDR_BUS_LEN-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0]   m0_data_i,
  input  logic [DATA_WIDTH-1:0]   m1_data_i,
  input  logic                    m0_wr_w_i,
  input  logic                    m0_wr_h_i,
  input  logic                    m0_wr_b_i,
  input  logic                    m1_wr_w_i,
  input  logic                    m1_wr_h_i,
  input  logic                    m1_wr_b_i,
  output logic                    m0_gnt_o,
  output logic                    m1_gnt_o,
  output logic                    m0_rd_valid_o,
  output logic                    m1_rd_valid_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    ram_cs_o,
  output logic [ADDR_BUS_LEN-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_in_o,
  output logic                    ram_write_w_o,
  output logic                    ram_write_h_o,
  output logic                    ram_write_b_o,
  input  logic [DATA_WIDTH-1:0]   ram_out_i
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} st_t;
  localparam logic [3:0] MB = 4'(MAX_BURST);
  st_t        st, st_nxt;
  logic       last, last_nxt, sel, any;
  logic [3:0] cnt, cnt_nxt;
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      st            <= IDLE;
      last          <= 1'b1;
      cnt           <= 4'd0;
      m0_rd_valid_o <= 1'b0;
      m1_rd_valid_o <= 1'b0;
    end else begin
      st            <= st_nxt;
      last          <= last_nxt;
      cnt           <= cnt_nxt;
      m0_rd_valid_o <= m0_gnt_o & ~(m0_wr_w_i | m0_wr_h_i | m0_wr_b_i);
      m1_rd_valid_o <= m1_gnt_o & ~(m1_wr_w_i | m1_wr_h_i | m1_wr_b_i);
    end
  end
  // sel picks master 1; only meaningful when some master requests
  always_comb begin
    any      = m0_req_i | m1_req_i;
    sel      = !m0_req_i ? 1'b1 : !m1_req_i ? 1'b0 :
               st == OWN0 ? (cnt >= MB) : st == OWN1 ? (cnt < MB) : !last;
    m0_gnt_o = any & ~sel;
    m1_gnt_o = any & sel;
    st_nxt   = !any ? IDLE : sel ? OWN1 : OWN0;
    last_nxt = any ? sel : last;
    cnt_nxt  = !any ? 4'd0 : st_nxt != st ? 4'd1 : cnt == 4'hf ? cnt : cnt + 4'd1;
    ram_cs_o      = any;
    ram_addr_o    = m1_gnt_o ? m1_addr_i : m0_gnt_o ? m0_addr_i : '0;
    ram_in_o      = m1_gnt_o ? m1_data_i : m0_gnt_o ? m0_data_i : '0;
    ram_write_w_o = m1_gnt_o ? m1_wr_w_i : m0_gnt_o & m0_wr_w_i;
    ram_write_h_o = m1_gnt_o ? m1_wr_h_i : m0_gnt_o & m0_wr_h_i;
    ram_write_b_o = m1_gnt_o ? m1_wr_b_i : m0_gnt_o & m0_wr_b_i;
    data_o        = ram_out_i;
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus with a read-return scoreboard for ram_arbiter
module tb_ram_arbiter;
  logic        clk_i = 1'b0, rst_i = 1'b0;
  logic        r0 = 1'b0, r1 = 1'b0;
  logic [11:0] a0 = 12'h001, a1 = 12'h002;
  logic [31:0] d0 = 32'h1111_0000, d1 = 32'h2222_0000;
  logic [2:0]  s0 = 3'b000, s1 = 3'b000;
  logic        m0_gnt_o, m1_gnt_o, m0_rd_valid_o, m1_rd_valid_o;
  logic        ram_cs_o, ram_write_w_o, ram_write_h_o, ram_write_b_o;
  logic [11:0] ram_addr_o;
  logic [31:0] data_o, ram_in_o, ram_out = 32'h0;
  int          errors = 0, checks = 0;
  typedef struct packed {logic [1:0] rv; logic [31:0] d;} exp_t;
  exp_t q[$];
  always #5 clk_i = ~clk_i;
  ram_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(r0), .m1_req_i(r1),
    .m0_addr_i(a0), .m1_addr_i(a1),
    .m0_data_i(d0), .m1_data_i(d1),
    .m0_wr_w_i(s0[2]), .m0_wr_h_i(s0[1]), .m0_wr_b_i(s0[0]),
    .m1_wr_w_i(s1[2]), .m1_wr_h_i(s1[1]), .m1_wr_b_i(s1[0]),
    .m0_gnt_o(m0_gnt_o), .m1_gnt_o(m1_gnt_o),
    .m0_rd_valid_o(m0_rd_valid_o), .m1_rd_valid_o(m1_rd_valid_o),
    .data_o(data_o), .ram_cs_o(ram_cs_o), .ram_addr_o(ram_addr_o), .ram_in_o(ram_in_o),
    .ram_write_w_o(ram_write_w_o), .ram_write_h_o(ram_write_h_o), .ram_write_b_o(ram_write_b_o),
    .ram_out_i(ram_out)
  );
  function automatic logic [31:0] pat(input logic [11:0] a);
    return a == 12'h010 ? 32'hDEADBEEF : {20'hC0FFE, a};
  endfunction
  // one-cycle-latency RAM whose contents are a fixed function of the address
  always @(posedge clk_i) ram_out <= ram_cs_o ? pat(ram_addr_o) : 32'h0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic [1:0] eg);
    exp_t e;
    @(negedge clk_i);
    chk({tag, "_gnt"}, 64'({m1_gnt_o, m0_gnt_o}), 64'(eg));
    if (eg != 2'b00) begin
      chk({tag, "_cs"}, 64'(ram_cs_o), 64'd1);
      chk({tag, "_addr"}, 64'(ram_addr_o), 64'(eg[1] ? a1 : a0));
      chk({tag, "_din"}, 64'(ram_in_o), 64'(eg[1] ? d1 : d0));
      chk({tag, "_wr"}, 64'({ram_write_w_o, ram_write_h_o, ram_write_b_o}), 64'(eg[1] ? s1 : s0));
    end else begin
      chk({tag, "_idle"}, 64'({ram_cs_o, ram_addr_o, ram_in_o, ram_write_w_o, ram_write_h_o, ram_write_b_o}), 64'd0);
    end
    e.rv = !rst_i ? 2'b00 : (eg[0] && s0 == 3'b000) ? 2'b01 : (eg[1] && s1 == 3'b000) ? 2'b10 : 2'b00;
    e.d  = e.rv[1] ? pat(a1) : pat(a0);
    q.push_back(e);
    @(posedge clk_i);
    #1;
    e = q.pop_front();
    chk({tag, "_rv"}, 64'({m1_rd_valid_o, m0_rd_valid_o}), 64'(e.rv));
    if (e.rv != 2'b00) chk({tag, "_data"}, 64'(data_o), 64'(e.d));
  endtask
  initial begin
    @(posedge clk_i);
    #1;
    r0 = 1'b1; r1 = 1'b1;
    for (int i = 0; i < 3; i++) step("rst", 2'b01);
    rst_i = 1'b1;
    for (int i = 0; i < 9; i++) step("burst", (i < 4 || i == 8) ? 2'b01 : 2'b10);
    r0 = 1'b0; r1 = 1'b0;
    step("idle", 2'b00);
    r0 = 1'b1; a0 = 12'h010;
    step("m0rd", 2'b01);
    r0 = 1'b0;
    step("idle2", 2'b00);
    r1 = 1'b1; a1 = 12'h123; d1 = 32'h0000_00A5; s1 = 3'b001;
    step("m1wr", 2'b10);
    r1 = 1'b0;
    step("idle3", 2'b00);
    r0 = 1'b1; r1 = 1'b1; s1 = 3'b000; a0 = 12'h020; a1 = 12'h030;
    step("tie", 2'b01);
    r1 = 1'b0; s0 = 3'b110; d0 = 32'h1234_5678;
    step("m0wr", 2'b01);
    s0 = 3'b000;
    step("m0a", 2'b01);
    r0 = 1'b0;
    step("drop", 2'b00);
    r0 = 1'b1; r1 = 1'b1; rst_i = 1'b0;
    step("last0", 2'b10);
    rst_i = 1'b1; r0 = 1'b0;
    step("post", 2'b10);
    r0 = 1'b1;
    for (int i = 0; i < 4; i++) step("rburst", i < 3 ? 2'b10 : 2'b01);
    chk("q_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
